// File: rtl/dsp_accum_seq_pkg.sv
// Shared types and widths for the DSP accumulate job sequencer.
package dsp_accum_seq_pkg;

  localparam int unsigned A_W       = 20;
  localparam int unsigned B_W       = 18;
  localparam int unsigned P_W       = 64;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned CMD_LEN_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    RESULT
  } state_t;

  // Per-job DSP configuration held from CLEAR through RESULT
  typedef struct packed {
    logic               sub;
    logic [SHIFT_W-1:0] shift;
    logic               sat;
  } job_cfg_t;

  // The shared term/drain counter must also hold ACC_LATENCY-1 (up to 6)
  function automatic int unsigned cnt_width(input int unsigned len_w);
    return (len_w > 32'd3) ? len_w : 32'd3;
  endfunction

endpackage

// File: rtl/dsp_accum_seq_if.sv
// Command, operand stream, result and DSP-control bundle of the accumulate sequencer.
interface dsp_accum_seq_if
  import dsp_accum_seq_pkg::*;
#(
  parameter int unsigned LEN_W = CMD_LEN_W
);

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [LEN_W-1:0]     cmd_len_i;
  logic                 cmd_sub_i;
  logic [SHIFT_W-1:0]   cmd_shift_i;
  logic                 cmd_sat_i;

  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [A_W-1:0]       s_a_i;
  logic [B_W-1:0]       s_b_i;

  logic                 r_valid_o;
  logic                 r_ready_i;
  logic [P_W-1:0]       r_data_o;

  logic                 busy_o;

  logic                 dsp_reset_o;
  logic                 dsp_subtract_o;
  logic                 dsp_load_acc_o;
  logic                 dsp_saturate_o;
  logic [SHIFT_W-1:0]   dsp_shift_o;
  logic [A_W-1:0]       dsp_a_o;
  logic [B_W-1:0]       dsp_b_o;
  logic [P_W-1:0]       dsp_p_i;

  // Host / DSP environment side
  modport master (
    output cmd_valid_i, cmd_len_i, cmd_sub_i, cmd_shift_i, cmd_sat_i,
    output s_valid_i, s_a_i, s_b_i, r_ready_i, dsp_p_i,
    input  cmd_ready_o, s_ready_o, r_valid_o, r_data_o, busy_o,
    input  dsp_reset_o, dsp_subtract_o, dsp_load_acc_o, dsp_saturate_o,
    input  dsp_shift_o, dsp_a_o, dsp_b_o
  );

  // Sequencer side
  modport slave (
    input  cmd_valid_i, cmd_len_i, cmd_sub_i, cmd_shift_i, cmd_sat_i,
    input  s_valid_i, s_a_i, s_b_i, r_ready_i, dsp_p_i,
    output cmd_ready_o, s_ready_o, r_valid_o, r_data_o, busy_o,
    output dsp_reset_o, dsp_subtract_o, dsp_load_acc_o, dsp_saturate_o,
    output dsp_shift_o, dsp_a_o, dsp_b_o
  );

endinterface

// File: rtl/dsp_accum_sequencer.sv
// Job-level controller: clears the DSP, streams len A/B terms into it, waits out the
// accumulator latency and returns the final P over a ready/valid result port.
module dsp_accum_sequencer
  import dsp_accum_seq_pkg::*;
#(
  parameter int unsigned ACC_LATENCY = 1,
  parameter int unsigned LEN_W       = CMD_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  dsp_accum_seq_if.slave   bus
);

  localparam int unsigned         CNT_W      = cnt_width(LEN_W);
  localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(ACC_LATENCY - 32'd1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [LEN_W-1:0]   job_len;
  job_cfg_t           job_cfg;
  logic [P_W-1:0]     r_data;
  logic               r_valid;
  logic               busy;

  logic               capture_c;
  logic               cmd_ready_c;
  logic               s_ready_c;
  logic               load_c;
  logic               clear_c;
  logic [A_W-1:0]     a_c;
  logic [B_W-1:0]     b_c;

  // Next-state, counter and stream-steering decode
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    capture_c   = 1'b0;
    cmd_ready_c = 1'b0;
    s_ready_c   = 1'b0;
    load_c      = 1'b0;
    clear_c     = 1'b0;
    a_c         = '0;
    b_c         = '0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid_i) state_next = CLEAR;
      end
      CLEAR: begin
        clear_c = 1'b1;
        if (job_len == '0) begin
          state_next = DRAIN;
          cnt_next   = DRAIN_LAST;
        end else begin
          state_next = ACCUM;
          cnt_next   = CNT_W'(job_len);
        end
      end
      ACCUM: begin
        s_ready_c = 1'b1;
        if (bus.s_valid_i) begin
          load_c = 1'b1;
          a_c    = bus.s_a_i;
          b_c    = bus.s_b_i;
          if (cnt == CNT_W'(1)) begin
            state_next = DRAIN;
            cnt_next   = DRAIN_LAST;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          capture_c  = 1'b1;
          state_next = RESULT;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESULT: begin
        if (bus.r_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, job fields and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      job_len <= '0;
      job_cfg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      r_valid <= (state_next == RESULT);
      busy    <= (state_next != IDLE);
      if (state == IDLE && bus.cmd_valid_i) begin
        job_len <= bus.cmd_len_i;
        job_cfg <= '{sub: bus.cmd_sub_i, shift: bus.cmd_shift_i, sat: bus.cmd_sat_i};
      end else if (state_next == IDLE) begin
        job_cfg <= '0;
      end
      if (capture_c) r_data <= bus.dsp_p_i;
    end
  end

  // Stream beats are never consumed while reset is held
  assign bus.cmd_ready_o    = cmd_ready_c;
  assign bus.s_ready_o      = s_ready_c & ~reset;
  assign bus.dsp_load_acc_o = load_c & ~reset;
  assign bus.dsp_a_o        = reset ? '0 : a_c;
  assign bus.dsp_b_o        = reset ? '0 : b_c;
  assign bus.dsp_reset_o    = reset | clear_c;
  assign bus.dsp_subtract_o = job_cfg.sub;
  assign bus.dsp_shift_o    = job_cfg.shift;
  assign bus.dsp_saturate_o = job_cfg.sat;
  assign bus.r_valid_o      = r_valid;
  assign bus.r_data_o       = r_data;
  assign bus.busy_o         = busy;

endmodule

// File: tb/tb_dsp_accum_sequencer.sv
// Bench for dsp_accum_sequencer: drives jobs against a behavioural DSP and checks result and timing.
`timescale 1ns/1ps
module tb_dsp_accum_sequencer;
  import dsp_accum_seq_pkg::*;

  localparam int unsigned LAT   = 3;
  localparam int unsigned LEN_W = 8;
  localparam longint SAT_MAX = 64'sd2147483647;
  localparam longint SAT_MIN = -64'sd2147483648;

  typedef struct {
    int     len;
    bit     sub;
    int     shift;
    bit     sat;
    int     gap_after;
    int     gap_len;
    int     rdy_hold;
    int     a[8];
    int     b[8];
    longint exp_data;
    int     exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  dsp_accum_seq_if #(.LEN_W(LEN_W)) bus ();

  dsp_accum_sequencer #(.ACC_LATENCY(LAT), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint shape(input longint v, input int sh, input bit sat);
    longint s;
    s = v >>> sh;
    if (sat) begin
      if (s > SAT_MAX) s = SAT_MAX;
      else if (s < SAT_MIN) s = SAT_MIN;
    end
    return s;
  endfunction

  // Behavioural DSP: accumulator plus LAT-1 output pipeline stages
  longint acc = 0, d1 = 0, d2 = 0, prod;
  assign prod = longint'(signed'(bus.dsp_a_o)) * longint'(signed'(bus.dsp_b_o));
  always @(posedge clk) begin
    if (bus.dsp_reset_o) acc <= 0;
    else if (bus.dsp_load_acc_o) acc <= bus.dsp_subtract_o ? acc - prod : acc + prod;
    d1 <= acc;
    d2 <= d1;
  end
  assign bus.dsp_p_i = 64'(shape(d2, int'(bus.dsp_shift_o), bus.dsp_saturate_o));

  function automatic void chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  function automatic vec_t mk(input int len, input bit sub, input int sh, input bit sat,
                              input int ga, input int gl, input int rh,
                              input int a0, input int da, input int b0,
                              input longint exp_data, input int exp_lat);
    vec_t v;
    v.len = len; v.sub = sub; v.shift = sh; v.sat = sat;
    v.gap_after = ga; v.gap_len = gl; v.rdy_hold = rh;
    for (int i = 0; i < 8; i++) begin
      v.a[i] = a0 + i * da;
      v.b[i] = b0;
    end
    v.exp_data = exp_data;
    v.exp_lat  = exp_lat;
    return v;
  endfunction

  // Reference: signed dot product, then the DSP's shift/saturate rule
  function automatic longint ref_result(input vec_t v);
    longint s;
    s = 0;
    for (int i = 0; i < v.len; i++)
      s += (v.sub ? -64'sd1 : 64'sd1) * longint'(v.a[i]) * longint'(v.b[i]);
    return shape(s, v.shift, v.sat);
  endfunction

  task automatic run_job(input vec_t v, input string nm);
    int beat, gap_left, cyc, lat, rst_cyc, load_err, stab_err;
    bit gap_done;
    logic [P_W-1:0] held;
    longint f_sub, f_shift, f_sat, f_busy;
    beat = 0; gap_left = 0; lat = -1; rst_cyc = 0; load_err = 0; stab_err = 0; gap_done = 0;
    f_sub = 0; f_shift = 0; f_sat = 0; f_busy = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_len_i   = LEN_W'(v.len);
    bus.cmd_sub_i   = v.sub;
    bus.cmd_shift_i = SHIFT_W'(v.shift);
    bus.cmd_sat_i   = v.sat;
    #1 chk({nm, " cmd_ready idle"}, longint'(bus.cmd_ready_o), 1);
    @(negedge clk);
    // Commands offered while busy must be ignored
    bus.cmd_len_i   = LEN_W'($urandom);
    bus.cmd_sub_i   = ~v.sub;
    bus.cmd_shift_i = SHIFT_W'($urandom);
    bus.cmd_sat_i   = ~v.sat;
    cyc = 1;
    while (cyc < 200) begin
      if (beat < v.len && gap_left == 0) begin
        bus.s_valid_i = 1'b1;
        bus.s_a_i = A_W'(v.a[beat]);
        bus.s_b_i = B_W'(v.b[beat]);
      end else begin
        bus.s_valid_i = 1'b0;
        bus.s_a_i = A_W'($urandom);
        bus.s_b_i = B_W'($urandom);
      end
      #1;
      if (cyc == 1) begin
        f_sub   = longint'(bus.dsp_subtract_o);
        f_shift = longint'(bus.dsp_shift_o);
        f_sat   = longint'(bus.dsp_saturate_o);
        f_busy  = longint'(bus.busy_o);
      end
      if (bus.r_valid_o) begin
        lat = cyc;
        break;
      end
      if (bus.dsp_reset_o) rst_cyc++;
      if (bus.dsp_load_acc_o != (bus.s_valid_i && bus.s_ready_o)) load_err++;
      if (bus.s_ready_o && !bus.s_valid_i && (bus.dsp_a_o != '0 || bus.dsp_b_o != '0)) load_err++;
      if (bus.s_valid_i && bus.s_ready_o) begin
        beat++;
        if (!gap_done && beat == v.gap_after) begin
          gap_left = v.gap_len;
          gap_done = 1;
        end
      end else if (!bus.s_valid_i && bus.s_ready_o && gap_left > 0) begin
        gap_left--;
      end
      @(negedge clk);
      cyc++;
    end
    bus.cmd_valid_i = 1'b0;
    bus.s_valid_i   = 1'b0;
    chk({nm, " cfg sub"}, f_sub, longint'(v.sub));
    chk({nm, " cfg shift"}, f_shift, longint'(v.shift));
    chk({nm, " cfg sat"}, f_sat, longint'(v.sat));
    chk({nm, " busy"}, f_busy, 1);
    chk({nm, " latency"}, longint'(lat), longint'(v.exp_lat));
    chk({nm, " beats"}, longint'(beat), longint'(v.len));
    chk({nm, " dsp_reset cycles"}, longint'(rst_cyc), 1);
    chk({nm, " load_acc"}, longint'(load_err), 0);
    if (lat < 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    chk({nm, " data"}, longint'(bus.r_data_o), v.exp_data);
    held = bus.r_data_o;
    for (int h = 0; h < v.rdy_hold; h++) begin
      @(negedge clk);
      #1;
      if (bus.r_data_o != held || bus.cmd_ready_o || !bus.r_valid_o) stab_err++;
    end
    chk({nm, " hold"}, longint'(stab_err), 0);
    bus.r_ready_i = 1'b1;
    @(negedge clk);
    bus.r_ready_i = 1'b0;
    #1;
    chk({nm, " r_valid after"}, longint'(bus.r_valid_o), 0);
    chk({nm, " idle after"}, longint'({bus.cmd_ready_o, bus.busy_o}), 2);
    chk({nm, " cfg cleared"}, longint'({bus.dsp_subtract_o, bus.dsp_shift_o, bus.dsp_saturate_o}), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int ge;
    bus.cmd_valid_i = 1'b0; bus.cmd_len_i = '0; bus.cmd_sub_i = 1'b0;
    bus.cmd_shift_i = '0;   bus.cmd_sat_i = 1'b0;
    bus.s_valid_i = 1'b0;   bus.s_a_i = '0; bus.s_b_i = '0; bus.r_ready_i = 1'b0;

    //          len sub sh sat ga gl rh   a0     da  b0       data        lat
    tbl[0] = mk(1, 0, 0, 0,  0, 0, 0,     5, 0,      2,         10, 6);
    tbl[1] = mk(3, 1, 0, 0,  0, 0, 2,     5, 0,      2,        -30, 8);
    tbl[2] = mk(1, 0, 3, 0,  0, 0, 1,     5, 0,      4,          2, 6);
    tbl[3] = mk(4, 0, 0, 0,  2, 2, 0,     1, 1,      3,         30, 11);
    tbl[4] = mk(0, 0, 0, 0,  0, 0, 5,     0, 0,      0,          0, 5);
    tbl[5] = mk(2, 0, 0, 1,  0, 0, 0, 524287, 0, 131071, 2147483647, 7);
    tbl[6] = mk(2, 1, 4, 0,  0, 0, 0,    -8, 0,     10,         10, 7);

    repeat (3) @(negedge clk);
    #1 chk("dsp_reset during reset", longint'(bus.dsp_reset_o), 1);
    reset = 1'b0;
    #1;
    chk("reset cmd_ready", longint'(bus.cmd_ready_o), 1);
    chk("reset outputs", longint'({bus.s_ready_o, bus.r_valid_o, bus.busy_o, bus.dsp_reset_o,
                                   bus.dsp_load_acc_o, bus.dsp_subtract_o, bus.dsp_saturate_o}), 0);
    chk("reset r_data", longint'(bus.r_data_o), 0);
    chk("reset dsp operands", longint'({bus.dsp_shift_o, bus.dsp_a_o, bus.dsp_b_o}), 0);

    for (int i = 0; i < 7; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 16; r++) begin
      v = mk(int'($urandom_range(0, 8)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
        v.a[i] = int'($urandom_range(0, 1048575)) - 524288;
        v.b[i] = int'($urandom_range(0, 262143)) - 131072;
      end
      ge = (v.gap_after >= 1 && v.gap_after < v.len) ? v.gap_len : 0;
      v.exp_data = ref_result(v);
      v.exp_lat  = v.len + 2 + int'(LAT) + ge;
      run_job(v, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a len=8 job's ACCUM phase
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_len_i = LEN_W'(8); bus.cmd_sub_i = 1'b0;
    bus.cmd_shift_i = '0;   bus.cmd_sat_i = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.s_valid_i = 1'b1; bus.s_a_i = A_W'(100); bus.s_b_i = B_W'(100);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midjob dsp_reset", longint'(bus.dsp_reset_o), 1);
    chk("midjob s_ready in reset", longint'(bus.s_ready_o), 0);
    chk("midjob load_acc in reset", longint'(bus.dsp_load_acc_o), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.s_valid_i = 1'b0;
    #1;
    chk("midjob r_valid", longint'(bus.r_valid_o), 0);
    chk("midjob idle", longint'({bus.cmd_ready_o, bus.busy_o}), 2);
    run_job(mk(1, 0, 0, 0, 0, 0, 0, -3, 0, 7, -21, 6), "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_accum_sequencer.md
# dsp_accum_sequencer

Job-level controller for the shifted/saturating multiply-accumulate DSP (`accum_output_shifted_saturated`). It accepts a dot-product command (term count, add/subtract, output shift, saturate) and streams A/B operand pairs into the DSP. It clears the accumulator at job start, waits out the DSP latency, and returns the final P through a ready/valid result port. It sits between a host command/stream source and a single DSP instance.

## Interface
- ACC_LATENCY, 1: cycles from A/B applied with load_acc high to P reflecting that term (range 1..7).
- LEN_W, 8: width of the term-count field.
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- cmd_valid_i / cmd_ready_o, in/out, 1: command handshake.
- cmd_len_i, in, LEN_W: number of A/B terms (0 legal).
- cmd_sub_i, in, 1: 1 gives P = P − A·B; 0 gives P = P + A·B.
- cmd_shift_i, in, 6: output right shift for the job.
- cmd_sat_i, in, 1: saturation enable for the job.
- s_valid_i / s_ready_o, in/out, 1: operand stream handshake.
- s_a_i, in, 20: signed A. s_b_i, in, 18: signed B.
- r_valid_o / r_ready_i, out/in, 1: result handshake.
- r_data_o, out, 64: signed captured P.
- busy_o, out, 1: high in every state except IDLE.
- dsp_reset_o, dsp_subtract_o, dsp_load_acc_o, dsp_saturate_o, out, 1 each: DSP controls.
- dsp_shift_o, out, 6; dsp_a_o, out, 20; dsp_b_o, out, 18: DSP operands and shift.
- dsp_p_i, in, 64: DSP accumulator output.

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, RESULT.
- IDLE: cmd_ready_o = 1. On a command handshake, latch len, sub, shift and sat; go to CLEAR.
- CLEAR: dsp_reset_o = 1 for one cycle. Load the term counter with len. If len = 0, go to DRAIN; otherwise go to ACCUM.
- ACCUM: s_ready_o = 1. When s_valid_i is high, drive dsp_a_o/dsp_b_o from the stream, set dsp_load_acc_o = 1, and decrement the counter. When s_valid_i is low, drive dsp_a_o/dsp_b_o = 0 and dsp_load_acc_o = 0; the accumulator holds. On the final handshake, go to DRAIN.
- DRAIN: hold for ACC_LATENCY cycles with load_acc = 0. On the last DRAIN cycle, capture dsp_p_i into r_data_o; go to RESULT.
- RESULT: r_valid_o = 1. r_data_o is stable until r_ready_i is high, then return to IDLE.
- dsp_subtract_o, dsp_shift_o and dsp_saturate_o carry the latched job fields from CLEAR through RESULT. In IDLE they are 0.
- Shift and saturate arithmetic is performed by the DSP. The sequencer does not modify P.
- Commands never overlap: a new command is accepted only in IDLE.

## Timing
- Reset values: state = IDLE, cmd_ready_o = 1 (IDLE is combinational), s_ready_o = 0, r_valid_o = 0, r_data_o = 0, busy_o = 0, all dsp_* = 0 except dsp_reset_o.
- dsp_reset_o = reset OR (state == CLEAR), so the DSP is cleared while reset is held.
- Latency with a gap-free stream: the command handshake is cycle 0; r_valid_o first rises in cycle len + 2 + ACC_LATENCY. This also holds for len = 0.
- Each stream gap cycle adds one cycle of latency.
- Reset mid-job, in any state: on the next edge, return to IDLE, drop r_valid_o, and discard the partial result. Stream beats offered during reset are not consumed.
- r_ready_i high in the same cycle r_valid_o rises: the handshake completes and state is IDLE on the next cycle.
- cmd_valid_i while busy is ignored, since cmd_ready_o = 0.

## Structure
- Shared package `dsp_accum_seq_pkg` holds:
  - the state enum;
  - A_W = 20, B_W = 18, P_W = 64, SHIFT_W = 6;
  - the command field widths.
- Single flat module, no sub-module. The drain counter and term counter share one counter register sized max(LEN_W, 3).
- The DSP is instantiated beside the sequencer in the wrapper, not inside it.

## Test plan
1. Command len = 1, add, shift 0; stream A = 5, B = 2 -> r_data_o = 10, with r_valid_o in cycle 3 + ACC_LATENCY.
2. Command len = 3, subtract; stream three beats of A = 5, B = 2 -> r_data_o = −30. dsp_reset_o is high exactly one cycle, in CLEAR.
3. Command len = 1, add, shift 3; stream A = 5, B = 4 -> r_data_o = 2.
4. Command len = 4, add; stream A = 1..4, B = 3, with s_valid_i low for 2 cycles after beat 2 -> r_data_o = 30. dsp_load_acc_o is low during the gap; latency grows by 2.
5. Command len = 0 -> r_data_o = 0 in cycle 2 + ACC_LATENCY with no stream beats consumed. Then hold r_ready_i low for 5 cycles -> r_data_o is stable and cmd_ready_o stays 0.
6. Assert reset for 1 cycle mid-ACCUM of a len = 8 job -> IDLE, r_valid_o = 0, dsp_reset_o high during reset. A following len = 1 job with A = −3, B = 7 -> r_data_o = −21.
